// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int WB_CTI_W = 3;
    localparam int WB_BTE_W = 2;

    localparam logic [WB_CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [WB_CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [WB_CTI_W-1:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone classic/registered-feedback bus bundle.
// The master modport drives the request side; the slave modport answers it.
interface wb_mem_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int AW = 30,
    parameter int DW = 32
) ();

    logic [AW-1:0]       adr;
    logic [DW-1:0]       dat_w;
    logic [DW-1:0]       dat_r;
    logic [DW/8-1:0]     sel;
    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_CTI_W-1:0] cti;
    logic [WB_BTE_W-1:0] bte;
    logic                ack;
    logic                err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_mem_arbiter_watchdog.sv
// Per-grant watchdog: counts strobed cycles without a slave response and
// flags when the count reaches TIMEOUT. Only built with WB_ARB_TIMEOUT_EN.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Count waiting cycles; any response or leaving the grant restarts it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT));

endmodule
`endif

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single-port memory.
// Whole bus cycles are granted; a grant ends only when its master drops cyc.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort hung cycles with err.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    wb_mem_arbiter_if.slave  m0,
    wb_mem_arbiter_if.slave  m1,
    wb_mem_arbiter_if.master s
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_mem_arbiter: TIMEOUT must be >= 2");
    end

    arb_state_t    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_w_q;
    logic          timeout;

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_clr;
    logic wd_inc;

    assign wd_clr = (state_q == IDLE) | s.ack | s.err;
    assign wd_inc = s.stb & ~s.ack & ~s.err;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (wd_clr),
        .inc       (wd_inc),
        .timeout   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Grant state and round-robin history; last_grant=1 lets m0 win first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next grant: arbitrate only from IDLE, release when the owner drops cyc.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc || timeout) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GNT1: begin
                if (!m1.cyc || timeout) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Remember the last address/data driven so they hold steady through IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            adr_q   <= '0;
            dat_w_q <= '0;
        end else if (state_q == GNT0) begin
            adr_q   <= m0.adr;
            dat_w_q <= m0.dat_w;
        end else if (state_q == GNT1) begin
            adr_q   <= m1.adr;
            dat_w_q <= m1.dat_w;
        end
    end

    // Bus muxes; acks are gated by the owner's cyc so a late ack is never seen.
    always_comb begin
        s.adr    = adr_q;
        s.dat_w  = dat_w_q;
        s.sel    = '0;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.cti    = '0;
        s.bte    = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
        case (state_q)
            GNT0: begin
                s.adr   = m0.adr;
                s.dat_w = m0.dat_w;
                s.sel   = m0.sel;
                s.cyc   = m0.cyc & ~timeout;
                s.stb   = m0.stb & ~timeout;
                s.we    = m0.we;
                s.cti   = m0.cti;
                s.bte   = m0.bte;
                m0.ack  = s.ack & m0.cyc;
                m0.err  = (s.err & m0.cyc) | timeout;
            end
            GNT1: begin
                s.adr   = m1.adr;
                s.dat_w = m1.dat_w;
                s.sel   = m1.sel;
                s.cyc   = m1.cyc & ~timeout;
                s.stb   = m1.stb & ~timeout;
                s.we    = m1.we;
                s.cti   = m1.cti;
                s.bte   = m1.bte;
                m1.ack  = s.ack & m1.cyc;
                m1.err  = (s.err & m1.cyc) | timeout;
            end
            default: ;
        endcase
    end

endmodule
